// File: rtl/rf_scoreboard_if.sv
// Issue/retire/status bundle between the ID-stage control and the RF write-in-flight scoreboard.
interface rf_scoreboard_if #(
  parameter int NREG = 16,
  parameter int AW   = 4
);
  logic            issue_vld;
  logic            issue_we;
  logic [AW-1:0]   issue_dst;
  logic            src1_vld;
  logic [AW-1:0]   src1_addr;
  logic            src2_vld;
  logic [AW-1:0]   src2_addr;
  logic            wb_we;
  logic [AW-1:0]   wb_dst;
  logic            flush;
  logic            stall;
  logic [NREG-1:0] pending;
  logic [2:0]      inflight;
  logic            err;

  modport master (
    output issue_vld, issue_we, issue_dst,
    output src1_vld, src1_addr, src2_vld, src2_addr,
    output wb_we, wb_dst, flush,
    input  stall, pending, inflight, err
  );

  modport slave (
    input  issue_vld, issue_we, issue_dst,
    input  src1_vld, src1_addr, src2_vld, src2_addr,
    input  wb_we, wb_dst, flush,
    output stall, pending, inflight, err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register count of RF writes in flight between ID and WB; stalls ID on RAW hazards and full counters.
// Optional macro RF_SCB_WB_BYPASS_EN: RF is write-before-read, so a source whose last write retires now does not stall.
module rf_scoreboard #(
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter int MAXPEND = 3,
  parameter int CW      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  rf_scoreboard_if.slave sb
);

  logic [CW-1:0]   count_q [NREG];
  logic [CW-1:0]   count_d [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic [2:0]      inflight_q, inflight_d;
  logic            err_q, err_d;

  logic            src_vld  [2];
  logic [AW-1:0]   src_addr [2];
  logic [1:0]      hazard;
  logic            full;
  logic            stall;
  logic            accept;
  logic            ret;
  logic            wb_live;

  assign src_vld[0]  = sb.src1_vld;
  assign src_vld[1]  = sb.src2_vld;
  assign src_addr[0] = sb.src1_addr;
  assign src_addr[1] = sb.src2_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic retire;
`ifdef RF_SCB_WB_BYPASS_EN
      assign retire = sb.wb_we & (sb.wb_dst == src_addr[gi]) &
                      (count_q[src_addr[gi]] == CW'(1));
`else
      assign retire = 1'b0;
`endif
      assign hazard[gi] = sb.issue_vld & src_vld[gi] & (src_addr[gi] != '0) &
                          (count_q[src_addr[gi]] != '0) & ~retire;
    end
  endgenerate

  // A full destination is still writable if its oldest write leaves at WB this same cycle.
  assign full = sb.issue_vld & sb.issue_we & (sb.issue_dst != '0) &
                (count_q[sb.issue_dst] == CW'(MAXPEND)) &
                ~(sb.wb_we & (sb.wb_dst == sb.issue_dst));

  assign stall   = hazard[0] | hazard[1] | full;
  assign accept  = sb.issue_vld & sb.issue_we & (sb.issue_dst != '0) & ~stall;
  assign wb_live = sb.wb_we & (sb.wb_dst != '0);
  assign ret     = wb_live & (count_q[sb.wb_dst] != '0);

  assign count_d[0] = '0;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_cnt
      logic inc, dec;
      assign inc = accept & (sb.issue_dst == AW'(gi));
      assign dec = ret & (sb.wb_dst == AW'(gi));
      always_comb begin
        count_d[gi] = count_q[gi];
        if (sb.flush)
          count_d[gi] = '0;
        else if (inc && !dec)
          count_d[gi] = count_q[gi] + CW'(1);
        else if (dec && !inc)
          count_d[gi] = count_q[gi] - CW'(1);
      end
    end
  endgenerate

  always_comb begin
    logic [7:0] total;
    total     = '0;
    pending_d = '0;
    for (int i = 0; i < NREG; i++) begin
      total        = total + 8'(count_d[i]);
      pending_d[i] = (count_d[i] != '0);
    end
    inflight_d = (total > 8'd7) ? 3'd7 : total[2:0];
  end

  // Retiring a register with nothing in flight means the pipeline and tracker disagree.
  assign err_d = err_q | (~sb.flush & wb_live & (count_q[sb.wb_dst] == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) count_q[i] <= '0;
      pending_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) count_q[i] <= count_d[i];
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign sb.stall    = stall;
  assign sb.pending  = pending_q;
  assign sb.inflight = inflight_q;
  assign sb.err      = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomised and directed stimulus for rf_scoreboard, checked against a per-register integer count model.
`timescale 1ns/1ps
module tb_rf_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_scoreboard_if #(.NREG(16), .AW(4)) sb ();

  rf_scoreboard #(.NREG(16), .AW(4), .MAXPEND(3), .CW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: number of writes each register still owes to WB, plus a sticky error flag.
  int m_cnt [16];
  int m_err;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_err = 0;
  endfunction

  function automatic bit src_blocks(input bit v, input int a);
    bit last_leaving;
    if (!sb.issue_vld || !v || a == 0 || m_cnt[a] == 0) return 1'b0;
`ifdef RF_SCB_WB_BYPASS_EN
    last_leaving = sb.wb_we && (int'(sb.wb_dst) == a) && (m_cnt[a] == 1);
`else
    last_leaving = 1'b0;
`endif
    return !last_leaving;
  endfunction

  function automatic bit model_stall();
    int d;
    bit full;
    d = int'(sb.issue_dst);
    full = sb.issue_vld && sb.issue_we && d != 0 && m_cnt[d] == 3 &&
           !(sb.wb_we && int'(sb.wb_dst) == d);
    return src_blocks(sb.src1_vld, int'(sb.src1_addr)) |
           src_blocks(sb.src2_vld, int'(sb.src2_addr)) | full;
  endfunction

  task automatic drive(input bit iv, input bit iw, input int id,
                       input bit s1v, input int s1a, input bit s2v, input int s2a,
                       input bit wwe, input int wd, input bit fl);
    sb.issue_vld = iv;  sb.issue_we = iw;  sb.issue_dst = 4'(id);
    sb.src1_vld  = s1v; sb.src1_addr = 4'(s1a);
    sb.src2_vld  = s2v; sb.src2_addr = 4'(s2a);
    sb.wb_we     = wwe; sb.wb_dst = 4'(wd);
    sb.flush     = fl;
  endtask

  // Called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic step(input string tag);
    bit exp_stall;
    bit acc;
    int wd, total;
    logic [15:0] exp_pend;
    #2;
    exp_stall = model_stall();
    check_val({tag, ".stall"}, sb.stall, exp_stall);
    acc = sb.issue_vld && sb.issue_we && sb.issue_dst != 0 && !exp_stall;
    @(posedge clk);
    if (sb.flush) begin
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    end else begin
      wd = int'(sb.wb_dst);
      if (sb.wb_we && wd != 0) begin
        if (m_cnt[wd] == 0) m_err = 1;
        else m_cnt[wd]--;
      end
      if (acc) m_cnt[int'(sb.issue_dst)]++;
    end
    #1;
    total = 0;
    exp_pend = '0;
    for (int r = 0; r < 16; r++) begin
      total += m_cnt[r];
      exp_pend[r] = (m_cnt[r] != 0);
    end
    check_val({tag, ".pending"}, sb.pending, exp_pend);
    check_val({tag, ".inflight"}, sb.inflight, (total > 7) ? 7 : total);
    check_val({tag, ".err"}, sb.err, m_err);
    @(negedge clk);
  endtask

  task automatic random_cycle(input bit clean_wb, input string tag);
    int cand [$];
    int wd;
    bit wwe;
    wwe = ($urandom_range(0, 2) == 0);
    wd  = $urandom_range(0, 7);
    if (clean_wb) begin
      for (int r = 1; r < 16; r++) if (m_cnt[r] != 0) cand.push_back(r);
      if (cand.size() == 0) wwe = 1'b0;
      else wd = cand[$urandom_range(0, cand.size() - 1)];
    end
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 5),
          $urandom_range(0, 1), $urandom_range(0, 5),
          $urandom_range(0, 1), $urandom_range(0, 5),
          wwe, wd, $urandom_range(0, 24) == 0);
    step(tag);
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_val("reset.stall", sb.stall, 0);
    check_val("reset.pending", sb.pending, 0);
    check_val("reset.inflight", sb.inflight, 0);
    check_val("reset.err", sb.err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW on R3: issue, then read it back while the write travels to WB.
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0); step("raw.issue");
    drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0); step("raw.wait1");
    drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0); step("raw.wait2");
    drive(1, 0, 0, 1, 3, 0, 0, 1, 3, 0); step("raw.wb");
    drive(1, 0, 0, 1, 3, 0, 0, 0, 0, 0); step("raw.after");

    // Fill R5, then a fourth with and without a same-cycle retire.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); step("full.fill");
    end
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); step("full.block");
    drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0); step("full.swap");

    // R0 is never tracked.
    drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0); step("r0.issue");

    // Flush with a simultaneous accept; then retire with no count sets err.
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 1); step("flush");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0); step("err.set");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step("err.hold");

    // Asynchronous reset mid-run, then clean random traffic (err must stay 0).
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); step("pre_rst");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("midrst.stall", sb.stall, 0);
    check_val("midrst.pending", sb.pending, 0);
    check_val("midrst.inflight", sb.inflight, 0);
    check_val("midrst.err", sb.err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) random_cycle(1'b1, "rnd_clean");
    for (int i = 0; i < 400; i++) random_cycle(1'b0, "rnd_any");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
